// File: rtl/altr_hps_strap_pkg.sv
// Shared types and constants for the HPS strap capture block.
package altr_hps_strap_pkg;

    // Qualification FSM states.
    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        SAMPLE = 2'd1,
        LOCKED = 2'd2
    } strap_state_e;

    // Flops in the strap input synchroniser.
    localparam int SYNC_DEPTH    = 2;

    // Edges spent in SETTLE so the synchroniser holds only post-reset data.
    localparam int SETTLE_CYCLES = SYNC_DEPTH + 1;

endpackage : altr_hps_strap_pkg

// File: rtl/altr_hps_bitsync_vec.sv
// WIDTH-wide multi-flop synchroniser for quasi-static strap inputs.
// Each bit is synchronised on its own; straps are only qualified later.
module altr_hps_bitsync_vec
    import altr_hps_strap_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [SYNC_DEPTH-1:0][WIDTH-1:0] stage_q;
    logic [SYNC_DEPTH-1:0][WIDTH-1:0] stage_d;

    // Shift the raw input into the first stage and move older samples along.
    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = din;
        for (int i = 1; i < SYNC_DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Synchroniser flops; reset clears every stage so no pre-reset value leaks through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling its pre-edge value.
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[SYNC_DEPTH-1];

endmodule : altr_hps_bitsync_vec

// File: rtl/altr_hps_strap_capture.sv
// Captures tie-cell / soft-strap values after reset, requires STABLE_CNT
// consecutive identical synchronised samples before locking them, and falls
// back to DEFAULT with an error flag if no stable value appears in TIMEOUT cycles.
module altr_hps_strap_capture
    import altr_hps_strap_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter int               STABLE_CNT = 4,
    parameter int               TIMEOUT    = 64,
    parameter logic [WIDTH-1:0] DEFAULT    = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] strap_in,
    input  logic             recapture,
    output logic [WIDTH-1:0] strap_out,
    output logic             strap_valid,
    output logic             strap_err
);

    localparam int STAB_W   = $clog2(STABLE_CNT + 1);
    localparam int TMO_W    = $clog2(TIMEOUT + 1);
    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);

    // Counter values at which the next edge completes the count (count+1 == limit).
    localparam logic [STAB_W-1:0]   STAB_LAST   = STAB_W'(STABLE_CNT - 1);
    localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(TIMEOUT - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

    logic [WIDTH-1:0]    sync_q;

    strap_state_e        state_q,       state_d;
    logic [SETTLE_W-1:0] settle_cnt_q,  settle_cnt_d;
    logic [WIDTH-1:0]    samp_q,        samp_d;
    logic [STAB_W-1:0]   stab_cnt_q,    stab_cnt_d;
    logic [TMO_W-1:0]    tmo_cnt_q,     tmo_cnt_d;
    logic [WIDTH-1:0]    strap_out_q,   strap_out_d;
    logic                strap_valid_q, strap_valid_d;
    logic                strap_err_q,   strap_err_d;
    logic                samp_match;

    altr_hps_bitsync_vec #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (strap_in),
        .dout (sync_q)
    );

    assign samp_match = (sync_q == samp_q);

    // Next-state, counter and output-register logic for the qualification FSM.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d       = state_q;
        settle_cnt_d  = settle_cnt_q;
        samp_d        = samp_q;
        stab_cnt_d    = stab_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        strap_out_d   = strap_out_q;
        strap_valid_d = strap_valid_q;
        strap_err_d   = strap_err_q;

        case (state_q)
            SETTLE: begin
                settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
                if (settle_cnt_q == SETTLE_LAST) begin
                    // Synchroniser now holds only post-reset data: take first sample.
                    samp_d       = sync_q;
                    stab_cnt_d   = STAB_W'(1);
                    tmo_cnt_d    = '0;
                    settle_cnt_d = '0;
                    state_d      = SAMPLE;
                end
            end

            SAMPLE: begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                if (samp_match) begin
                    stab_cnt_d = stab_cnt_q + STAB_W'(1);
                end else begin
                    samp_d     = sync_q;
                    stab_cnt_d = STAB_W'(1);
                end

                // Lock is checked first so it wins over a coincident timeout.
                if (samp_match && (stab_cnt_q == STAB_LAST)) begin
                    strap_out_d   = samp_q;
                    strap_valid_d = 1'b1;
                    strap_err_d   = 1'b0;
                    stab_cnt_d    = '0;
                    tmo_cnt_d     = '0;
                    state_d       = LOCKED;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    strap_out_d   = DEFAULT;
                    strap_valid_d = 1'b1;
                    strap_err_d   = 1'b1;
                    stab_cnt_d    = '0;
                    tmo_cnt_d     = '0;
                    state_d       = LOCKED;
                end
            end

            LOCKED: begin
                // strap_out keeps its last value while the straps are re-qualified.
                if (recapture) begin
                    strap_valid_d = 1'b0;
                    strap_err_d   = 1'b0;
                    settle_cnt_d  = '0;
                    state_d       = SETTLE;
                end
            end

            default: begin
                state_d = SETTLE;
            end
        endcase
    end

    // State, counter and output registers; reset restores the pre-capture state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= SETTLE;
            settle_cnt_q  <= '0;
            samp_q        <= '0;
            stab_cnt_q    <= '0;
            tmo_cnt_q     <= '0;
            strap_out_q   <= DEFAULT;
            strap_valid_q <= 1'b0;
            strap_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            settle_cnt_q  <= settle_cnt_d;
            samp_q        <= samp_d;
            stab_cnt_q    <= stab_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            strap_out_q   <= strap_out_d;
            strap_valid_q <= strap_valid_d;
            strap_err_q   <= strap_err_d;
        end
    end

    assign strap_out   = strap_out_q;
    assign strap_valid = strap_valid_q;
    assign strap_err   = strap_err_q;

endmodule : altr_hps_strap_capture

// File: tb/tb_altr_hps_strap_capture.sv
// Directed testbench for altr_hps_strap_capture. Inputs change and outputs
// are sampled on the falling edge; edges are counted from reset release.
module tb_altr_hps_strap_capture;

    logic       clk;
    logic       rst;
    logic [7:0] strap_in;
    logic       recapture;
    logic [7:0] strap_out;
    logic       strap_valid;
    logic       strap_err;

    // Second instance tuned so that lock and timeout land on the same edge.
    logic       rst2;
    logic [7:0] strap_in2;
    logic       recapture2;
    logic [7:0] strap_out2;
    logic       strap_valid2;
    logic       strap_err2;

    int checks;
    int errors;

    altr_hps_strap_capture dut (
        .clk         (clk),
        .rst         (rst),
        .strap_in    (strap_in),
        .recapture   (recapture),
        .strap_out   (strap_out),
        .strap_valid (strap_valid),
        .strap_err   (strap_err)
    );

    altr_hps_strap_capture #(
        .WIDTH      (8),
        .STABLE_CNT (4),
        .TIMEOUT    (6),
        .DEFAULT    (8'hC3)
    ) dut2 (
        .clk         (clk),
        .rst         (rst2),
        .strap_in    (strap_in2),
        .recapture   (recapture2),
        .strap_out   (strap_out2),
        .strap_valid (strap_valid2),
        .strap_err   (strap_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then return to the falling edge for sampling/driving.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Outputs of the main instance against expected values.
    task automatic expect_out(input string name, input logic [7:0] exp_out,
                              input logic exp_valid, input logic exp_err);
        checks++;
        if (strap_out !== exp_out || strap_valid !== exp_valid || strap_err !== exp_err) begin
            errors++;
            $display("FAIL %s: got out=%h valid=%b err=%b, expected out=%h valid=%b err=%b",
                     name, strap_out, strap_valid, strap_err, exp_out, exp_valid, exp_err);
        end
    endtask

    // Assert reset with a given strap value, then release on a falling edge.
    task automatic do_reset(input logic [7:0] value);
        rst       = 1'b1;
        strap_in  = value;
        recapture = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        strap_in   = 8'hA5;
        recapture  = 1'b0;
        rst2       = 1'b1;
        strap_in2  = 8'h11;
        recapture2 = 1'b0;
        tick();
        tick();
        expect_out("reset_values", 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_constant_lock();
        rst = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            tick();
            expect_out($sformatf("const_before_lock_e%0d", e), 8'h00, 1'b0, 1'b0);
        end
        tick();
        expect_out("const_lock_e6", 8'hA5, 1'b1, 1'b0);
    endtask

    task automatic test_locked_hold_and_recapture();
        int bad;
        strap_in = 8'h3C;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (strap_out !== 8'hA5 || strap_valid !== 1'b1 || strap_err !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL locked_hold: %0d of 10 cycles changed, expected out=a5 held", bad);
        end
        recapture = 1'b1;
        tick();                        // edge R accepts recapture
        recapture = 1'b0;
        expect_out("recapture_R", 8'hA5, 1'b0, 1'b0);
        for (int e = 1; e <= 4; e++) tick();
        expect_out("recapture_R4", 8'hA5, 1'b0, 1'b0);
        tick();
        expect_out("recapture_R5", 8'hA5, 1'b0, 1'b0);
        tick();
        expect_out("recapture_R6", 8'h3C, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_sample();
        strap_in  = 8'h77;
        recapture = 1'b1;
        tick();                        // edge R
        recapture = 1'b0;
        for (int e = 1; e <= 4; e++) tick();   // R+3 enters SAMPLE, R+4 stab_cnt=2
        expect_out("mid_sample_before_rst", 8'h3C, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        expect_out("async_reset", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 5; e++) tick();
        expect_out("after_rst_e5", 8'h00, 1'b0, 1'b0);
        tick();
        expect_out("after_rst_e6", 8'h77, 1'b1, 1'b0);
    endtask

    task automatic test_glitch();
        do_reset(8'h5A);
        tick();
        tick();
        tick();                        // edge 3: first sample taken
        strap_in = 8'h5B;              // seen by the edge 4 flop only
        tick();
        strap_in = 8'h5A;
        for (int e = 5; e <= 9; e++) tick();
        expect_out("glitch_e9", 8'h00, 1'b0, 1'b0);
        tick();
        expect_out("glitch_e10", 8'h5A, 1'b1, 1'b0);
    endtask

    task automatic test_timeout();
        int early;
        do_reset(8'h00);
        early = 0;
        for (int e = 1; e <= 66; e++) begin
            tick();
            if (strap_valid !== 1'b0 || strap_err !== 1'b0) early++;
            strap_in = ~strap_in;
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL timeout_early: outputs asserted on %0d edges before 67, expected 0", early);
        end
        tick();
        expect_out("timeout_e67", 8'h00, 1'b1, 1'b1);
    endtask

    task automatic test_lock_timeout_tie();
        rst2      = 1'b1;
        strap_in2 = 8'h11;
        tick();
        rst2 = 1'b0;
        tick();
        tick();
        tick();                        // edge 3
        strap_in2 = 8'h22;
        for (int e = 4; e <= 8; e++) tick();
        checks++;
        if (strap_valid2 !== 1'b0) begin
            errors++;
            $display("FAIL tie_e8: got valid=%b, expected valid=0", strap_valid2);
        end
        tick();                        // edge 9: lock and timeout together
        checks++;
        if (strap_out2 !== 8'h22 || strap_valid2 !== 1'b1 || strap_err2 !== 1'b0) begin
            errors++;
            $display("FAIL tie_e9: got out=%h valid=%b err=%b, expected out=22 valid=1 err=0",
                     strap_out2, strap_valid2, strap_err2);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        @(negedge clk);
        test_reset();
        test_constant_lock();
        test_locked_hold_and_recapture();
        test_reset_mid_sample();
        test_glitch();
        test_timeout();
        test_lock_timeout_tie();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_altr_hps_strap_capture
